serial_word_collector: RTL
==========================

// Module: serial_word_collector
// PURPOSE
//  Receive side of the universal shift register's serial outputs (left/right serial out).
//  Accepts one qualified bit per clock and packs WORD_W bits into a word, MSB-first or LSB-first.
//  Buffers completed words in a small FIFO.
//  Hands them to the PRNG consumer over a valid/ready interface.
// PARAMETERS
//  WORD_W  4  bits per assembled word (>=2)
//  DEPTH   4  output FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1                    clock, all logic on rising edge
//  rst         in   1                    synchronous reset, active-high
//  bit_in      in   1                    serial data bit
//  bit_valid   in   1                    bit_in is consumed this cycle
//  msb_first   in   1                    1: first bit lands in MSB; 0: first bit lands in LSB
//  flush       in   1                    discard the partial word
//  word_dout   out  WORD_W               FIFO head word
//  word_valid  out  1                    FIFO not empty
//  word_ready  in   1                    consumer accepts the head word
//  bit_count   out  $clog2(WORD_W+1)     bits held in the partial word
//  fifo_level  out  $clog2(DEPTH+1)      number of words stored
//  overflow    out  1                    sticky: a completed word was dropped
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 (word_dout=0, word_valid=0, bit_count=0, fifo_level=0, overflow=0).
//   - Assembly register and FIFO pointers are cleared.
//   - Reset applied mid-word or mid-burst discards everything; no partial output.
//  Assembly:
//   - msb_first is latched on the first bit of each word (bit_count==0).
//   - Changes to msb_first mid-word are ignored until the next word.
//   - msb_first=1: shreg <= {shreg[W-2:0], bit_in}.
//   - msb_first=0: shreg <= {bit_in, shreg[W-1:1]}.
//   - bit_count increments on each accepted bit; it wraps to 0 on the WORD_W-th bit.
//  Completion:
//   - The WORD_W-th bit builds the word combinationally and pushes it in the same edge.
//   - word_valid rises the cycle after the edge that accepted the last bit (1-cycle latency when the FIFO was empty).
//  Flush:
//   - bit_count<=0 and the partial word is discarded.
//   - flush has priority over a simultaneous bit_valid; that bit is dropped.
//   - flush does not affect FIFO contents.
//  FIFO:
//   - Pop occurs when word_valid && word_ready.
//   - Order is strictly first-in, first-out.
//   - word_dout is the registered head; it is 0 when the FIFO is empty.
//  Full:
//   - Push while full without a same-cycle pop: the word is dropped and overflow<=1 (held until rst).
//   - Push while full with a same-cycle pop: both occur, level is unchanged, no overflow.
//   - Push while empty with ready=1: no bypass; the word appears next cycle.
//  Empty:
//   - word_ready with the FIFO empty has no effect.
//  fifo_level arithmetic: level + push_ok - pop; never exceeds DEPTH and never goes below 0.
// STRUCTURE
//  Shared package prng_pkg:
//   - USR select encodings: SEL_HOLD=2'b00, SEL_CMPL=2'b01, SEL_SHR=2'b10, SEL_SHL=2'b11.
//   - Default word width constant.
//  Sub-module sync_fifo #(WIDTH, DEPTH):
//   - Pointer-based with an extra wrap bit.
//   - Ports: push/pop/full/empty/level.
//  Top module keeps the shift/count/flush logic and instantiates sync_fifo.
// TESTING (WORD_W=4, DEPTH=4)
//  1. rst=1 for 2 cycles -> word_valid=0, bit_count=0, fifo_level=0, overflow=0, word_dout=4'b0000.
//  2. msb_first=1, bits 1,0,1,1 back-to-back -> next cycle word_valid=1, word_dout=4'b1011, bit_count=0.
//  3. msb_first=0, bits 1,0,1,1 -> word_dout=4'b1101; toggling msb_first after bit 1 leaves the result unchanged.
//  4. word_ready=0, push 5 words 0x1..0x5 -> level=4, overflow=1 after the 5th; pops return 0x1,0x2,0x3,0x4.
//  5. FIFO full, word_ready=1 in the completion cycle -> level stays 4, overflow stays 0, new word sits at the tail.
//  6. Bits 1,1, flush (with bit_valid=1), then 0,1,1,0 msb_first -> single word 4'b0110.
//     rst after 2 bits -> bit_count=0 and no word is produced.

Source files
------------

// File: rtl/prng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prng_pkg
// Description : Shared constants for the PRNG datapath: universal shift
//               register select encodings and the default collector width.
// Revision    : 1.0 - initial release
// ============================================================================
package prng_pkg;

    // Universal shift register select encodings
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_CMPL = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_SHL  = 2'b11;

    // Default number of serial bits packed into one word
    localparam int c_default_word_w = 4;

endpackage : prng_pkg
`default_nettype wire

// File: rtl/serial_word_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with wrap-bit pointers. The head entry is
//               presented on dout and forced to zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    // Status flags and qualified push/pop; a push into a full FIFO only
    // succeeds when the head leaves in the same cycle.
    always_comb begin
        empty     = (r_wr_ptr == r_rd_ptr);
        full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
        level     = r_wr_ptr - r_rd_ptr;
        dout      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end

    // Storage array; contents are only read once written, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read and write pointers with extra wrap bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_collector
// Description : Packs qualified serial bits into WORD_W-bit words (MSB- or
//               LSB-first, order latched per word), queues completed words
//               in a FIFO and hands them out over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector
    import prng_pkg::*;
#(
    parameter int WORD_W = c_default_word_w,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          msb_first,
    input  logic                          flush,
    output logic [WORD_W-1:0]             word_dout,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(WORD_W+1)-1:0]   bit_count,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level,
    output logic                          overflow
);

    localparam int              CW         = $clog2(WORD_W+1);
    localparam logic [CW-1:0]   c_last_idx = CW'(WORD_W-1);

    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] w_shreg_next;
    logic [CW-1:0]     r_count;
    logic              r_msb;
    logic              w_msb_eff;
    logic              w_accept;
    logic              w_last;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              r_overflow;

    // Next assembly value; the bit order is taken live on the first bit of
    // a word and from the latched copy for the rest of it.
    always_comb begin
        w_accept     = bit_valid && !flush;
        w_msb_eff    = (r_count == '0) ? msb_first : r_msb;
        w_shreg_next = w_msb_eff ? {r_shreg[WORD_W-2:0], bit_in}
                                 : {bit_in, r_shreg[WORD_W-1:1]};
        w_last       = (r_count == c_last_idx);
        w_push       = w_accept && w_last;
        w_pop        = !w_empty && word_ready;
    end

    // Assembly register, bit counter and per-word order latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_count <= '0;
            r_msb   <= 1'b0;
        end else if (flush) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (bit_valid) begin
            r_shreg <= w_shreg_next;
            if (r_count == '0) r_msb <= msb_first;
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    // Sticky flag: a completed word found the FIFO full with no pop to free a slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_shreg_next),
        .pop   (w_pop),
        .dout  (word_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    assign word_valid = !w_empty;
    assign bit_count  = r_count;
    assign overflow   = r_overflow;

endmodule : serial_word_collector
`default_nettype wire
